// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: shared state encoding, data width default and baud divisor helper
package uart_fifo_pkg;
    localparam int DATA_W_DEF = 8;
    typedef enum logic [6:0] {
        IDLE   = 7'b0000001,
        RD     = 7'b0000010,
        LATCH  = 7'b0000100,
        START  = 7'b0001000,
        DATA   = 7'b0010000,
        PARITY = 7'b0100000,
        STOP   = 7'b1000000
    } state_t;
    function automatic int bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: counts 0..BPS_CNT-1 while enabled, pulses wrap on the last cycle of each bit
module uart_baud_cnt #(
    parameter int BPS_CNT = 434
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr,
    output logic wrap
);
    localparam int CW = $clog2(BPS_CNT);
    logic [CW-1:0] baud_cnt;
    assign wrap = baud_cnt == CW'(BPS_CNT - 1);
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) baud_cnt <= '0;
        else baud_cnt <= (clr || wrap) ? '0 : baud_cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and sends them as 8N1 UART frames.
// Define UART_PARITY_EN to insert an even-parity bit after the data bits.
module fifo_uart_tx
    import uart_fifo_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115_200,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              uart_txd,
    output logic              tx_busy,
    output logic              tx_done
);
    localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
    localparam int BW      = $clog2(DATA_W);

    state_t            state, state_nx;
    logic [DATA_W-1:0] shift_reg, shift_nx;
    logic [BW-1:0]     bit_cnt, bit_nx;
    logic              txd_nx, rd_nx, busy_nx, wrap, clr;
`ifdef UART_PARITY_EN
    logic              parity, parity_nx;
`endif

    // the baud counter only runs while a bit is on the line
    assign clr     = (state == IDLE) || (state == RD) || (state == LATCH);
    assign tx_done = (state == STOP) && wrap;

    uart_baud_cnt #(.BPS_CNT(BPS_CNT)) u_baud (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clr     (clr),
        .wrap    (wrap)
    );

    always_comb begin
        state_nx  = state;
        shift_nx  = shift_reg;
        bit_nx    = bit_cnt;
        txd_nx    = uart_txd;
        rd_nx     = 1'b0;
        busy_nx   = tx_busy;
`ifdef UART_PARITY_EN
        parity_nx = parity;
`endif
        case (state)
            IDLE: begin
                txd_nx = 1'b1;
                if (!fifo_empty) begin
                    rd_nx    = 1'b1;
                    busy_nx  = 1'b1;
                    state_nx = RD;
                end
            end
            RD: state_nx = LATCH;
            LATCH: begin
                shift_nx  = fifo_dout;
                txd_nx    = 1'b0;
                state_nx  = START;
`ifdef UART_PARITY_EN
                parity_nx = ^fifo_dout;
`endif
            end
            START: if (wrap) begin
                txd_nx   = shift_reg[0];
                bit_nx   = '0;
                state_nx = DATA;
            end
            // txd always mirrors shift_reg[0] while in DATA
            DATA: if (wrap) begin
                shift_nx = shift_reg >> 1;
                if (bit_cnt == BW'(DATA_W - 1)) begin
                    bit_nx   = '0;
`ifdef UART_PARITY_EN
                    txd_nx   = parity;
                    state_nx = PARITY;
`else
                    txd_nx   = 1'b1;
                    state_nx = STOP;
`endif
                end else begin
                    bit_nx = bit_cnt + 1'b1;
                    txd_nx = shift_reg[1];
                end
            end
            PARITY: if (wrap) begin
                txd_nx   = 1'b1;
                state_nx = STOP;
            end
            STOP: if (wrap) begin
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                txd_nx   = 1'b1;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            uart_txd   <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_busy    <= 1'b0;
`ifdef UART_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            bit_cnt    <= bit_nx;
            uart_txd   <= txd_nx;
            fifo_rd_en <= rd_nx;
            tx_busy    <= busy_nx;
`ifdef UART_PARITY_EN
            parity     <= parity_nx;
`endif
        end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench; a line monitor decodes frames and checks them against queued bytes
module tb_fifo_uart_tx;
    localparam int BPS = 10;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       force_empty = 1'b0;
    logic       fifo_empty, fifo_rd_en, uart_txd, tx_busy, tx_done;
    logic [7:0] fifo_dout = 8'h00;
    logic [7:0] mem [256];
    int         wr_ptr = 0, rd_ptr = 0, cyc = 0;
    int         checks = 0, errors = 0;
    logic [7:0] exp_q[$];
    int         rd_cyc[$], starts[$], dones[$];
    logic       prev_rd = 1'b0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);
    always @(posedge sys_clk)
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end

    fifo_uart_tx #(.CLK_FREQ(1_000_000), .UART_BPS(100_000), .DATA_W(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr++;
        exp_q.push_back(b);
    endtask

    // pop monitor: record every pop and flag back-to-back strobes
    always @(negedge sys_clk) begin
        if (fifo_rd_en) begin
            rd_cyc.push_back(cyc);
            chk("rd_en_single", int'(prev_rd), 0);
        end
        prev_rd <= fifo_rd_en;
    end

    // line monitor: every bit must hold exactly BPS cycles; compare decoded byte with the scoreboard
    initial begin
        int s, dc;
        logic [NB-1:0] fr;
        logic [7:0] e;
        bit ab, stab;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && uart_txd === 1'b0) begin
                s = cyc; dc = -1; ab = 0; stab = 1; fr = '0;
                chk("busy_in_frame", int'(tx_busy), 1);
                for (int b = 0; b < NB && !ab; b++)
                    for (int k = 0; k < BPS && !ab; k++) begin
                        if (b != 0 || k != 0) @(negedge sys_clk);
                        if (sys_rst) ab = 1;
                        else begin
                            if (k == 0) fr[b] = uart_txd;
                            else if (uart_txd !== fr[b]) stab = 0;
                            if (tx_done === 1'b1) dc = cyc;
                        end
                    end
                if (!ab) begin
                    chk("bit_stable", int'(stab), 1);
                    chk("start_bit", int'(fr[0]), 0);
                    chk("stop_bit", int'(fr[NB-1]), 1);
                    chk("tx_done_cycle", dc, s + NB * BPS - 1);
                    if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("data", int'(fr[8:1]), int'(e));
`ifdef UART_PARITY_EN
                        chk("parity", int'(fr[9]), int'(^e));
`endif
                    end
                    starts.push_back(s);
                    dones.push_back(dc);
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int t = 0;
        while ((exp_q.size() != 0 || tx_busy || wr_ptr != rd_ptr) && t < budget) begin
            @(posedge sys_clk); #1; t++;
        end
        chk("drain_in_time", int'(t < budget), 1);
        repeat (5) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_rd(input int budget);
        int t = 0;
        do begin @(posedge sys_clk); #1; t++; end while (!fifo_rd_en && t < budget);
        chk("pop_in_time", int'(fifo_rd_en), 1);
    endtask

    task automatic chk_timing(input int n, input bit b2b);
        chk("pop_count", rd_cyc.size(), n);
        chk("frame_count", starts.size(), n);
        for (int i = 0; i < n && i < rd_cyc.size() && i < starts.size(); i++) begin
            chk("pop_to_start", starts[i] - rd_cyc[i], 2);
            if (b2b && i > 0) chk("frame_gap", starts[i] - dones[i-1], 4);
        end
        rd_cyc.delete(); starts.delete(); dones.delete();
    endtask

    initial begin
        int n, bad;
        logic [7:0] b;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_txd", int'(uart_txd), 1);
        chk("rst_rd_en", int'(fifo_rd_en), 0);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_done", int'(tx_done), 0);
        sys_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge sys_clk); #1;
            if (uart_txd !== 1'b1 || fifo_rd_en !== 1'b0 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        n = cyc;
        push(8'hA5);
        wait_drain(400);
        if (rd_cyc.size() > 0) chk("a5_pop_cycle", rd_cyc[0], n + 1);
        if (dones.size() > 0) chk("a5_done_cycle", dones[0], n + 2 + NB * BPS);
        chk_timing(1, 0);

        push(8'h00); push(8'hFF); push(8'h55);
        wait_drain(800);
        chk_timing(3, 1);

        push(8'h3C); push(8'h81);
        wait_rd(50);
        repeat (46) @(posedge sys_clk);
        #1;
        chk("busy_before_rst", int'(tx_busy), 1);
        sys_rst = 1'b1;
        #1;
        chk("mid_rst_txd", int'(uart_txd), 1);
        chk("mid_rst_busy", int'(tx_busy), 0);
        chk("mid_rst_rd_en", int'(fifo_rd_en), 0);
        chk("mid_rst_done", int'(tx_done), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        void'(exp_q.pop_front());
        rd_cyc.delete(); starts.delete(); dones.delete();
        sys_rst = 1'b0;
        wait_drain(400);
        chk_timing(1, 0);

        push(8'hA5); push(8'h07);
        wait_drain(600);
        chk_timing(2, 1);

        push(8'h5A);
        wait_rd(50);
        force_empty = 1'b1;
        @(posedge sys_clk); #1;
        force_empty = 1'b0;
        wait_drain(400);
        chk_timing(1, 0);

        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            push(b);
            repeat ($urandom_range(0, 250)) @(posedge sys_clk);
            #1;
        end
        wait_drain(4000);
        chk("random_pops", rd_cyc.size(), 24);
        chk("random_frames", starts.size(), 24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
